mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one memory port between an
// instruction-fetch requester and a data requester, with a wait timeout.
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 15,
  localparam int unsigned AW = 32,
  localparam int unsigned DW = 32,
  localparam int unsigned SW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_inst,
  output logic          if_ack,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  input  logic [SW-1:0] d_sel,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic          err,
  output logic          mem_ce,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [SW-1:0] mem_sel,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          stallreq_if,
  output logic          stallreq_mem
);

  localparam int unsigned CW = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

  state_t        state, state_d;
  owner_t        owner, owner_d;
  owner_t        last_grant, last_grant_d;
  owner_t        grant;
  logic [CW-1:0] wait_cnt, wait_cnt_d;
  logic          done;

  logic          mem_ce_d, mem_we_d;
  logic [AW-1:0] mem_addr_d;
  logic [DW-1:0] mem_wdata_d;
  logic [SW-1:0] mem_sel_d;
  logic [DW-1:0] if_inst_d, d_rdata_d;
  logic          if_ack_d, d_ack_d, err_d;

  // Stall the pipeline while a request is outstanding and not yet acknowledged
  assign stallreq_if  = if_req & ~if_ack;
  assign stallreq_mem = d_req & ~d_ack;

  // Round-robin pick: on a tie, favour the requester not granted last time
  always_comb begin
    grant = OWN_IF;
    if (if_req && d_req) begin
      grant = (last_grant == OWN_IF) ? OWN_D : OWN_IF;
    end else if (d_req) begin
      grant = OWN_D;
    end
  end

  // Next state, transaction bookkeeping and next values of registered outputs
  always_comb begin
    state_d      = state;
    owner_d      = owner;
    last_grant_d = last_grant;
    wait_cnt_d   = wait_cnt;
    done         = 1'b0;
    mem_ce_d     = mem_ce;
    mem_we_d     = mem_we;
    mem_addr_d   = mem_addr;
    mem_wdata_d  = mem_wdata;
    mem_sel_d    = mem_sel;
    if_inst_d    = if_inst;
    d_rdata_d    = d_rdata;
    if_ack_d     = 1'b0;
    d_ack_d      = 1'b0;
    err_d        = 1'b0;

    case (state)
      IDLE: begin
        mem_ce_d = 1'b0;
        if (if_req || d_req) begin
          owner_d      = grant;
          last_grant_d = grant;
          wait_cnt_d   = '0;
          mem_ce_d     = 1'b1;
          state_d      = BUSY;
          if (grant == OWN_D) begin
            mem_we_d    = d_we;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            mem_sel_d   = d_sel;
          end else begin
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr;
            mem_wdata_d = '0;
            mem_sel_d   = '1;
          end
        end
      end

      BUSY: begin
        if (mem_ready) begin
          done = 1'b1;
          if (owner == OWN_IF) begin
            if_inst_d = mem_rdata;
          end else if (!mem_we) begin
            d_rdata_d = mem_rdata;
          end
        end else if (wait_cnt == CW'(TIMEOUT)) begin
          // Abort: the owner sees an all-zero read value alongside err
          done  = 1'b1;
          err_d = 1'b1;
          if (owner == OWN_IF) begin
            if_inst_d = '0;
          end else begin
            d_rdata_d = '0;
          end
        end else begin
          wait_cnt_d = wait_cnt + CW'(1);
        end

        if (done) begin
          state_d  = RESP;
          mem_ce_d = 1'b0;
          mem_we_d = 1'b0;
          if_ack_d = (owner == OWN_IF);
          d_ack_d  = (owner == OWN_D);
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d  = IDLE;
        mem_ce_d = 1'b0;
        mem_we_d = 1'b0;
      end
    endcase
  end

  // FSM state, ownership and wait counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      owner      <= OWN_IF;
      last_grant <= OWN_IF;
      wait_cnt   <= '0;
    end else begin
      state      <= state_d;
      owner      <= owner_d;
      last_grant <= last_grant_d;
      wait_cnt   <= wait_cnt_d;
    end
  end

  // Registered memory port, read registers and completion flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_ce    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_sel   <= '0;
      if_inst   <= '0;
      d_rdata   <= '0;
      if_ack    <= 1'b0;
      d_ack     <= 1'b0;
      err       <= 1'b0;
    end else begin
      mem_ce    <= mem_ce_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      mem_sel   <= mem_sel_d;
      if_inst   <= if_inst_d;
      d_rdata   <= d_rdata_d;
      if_ack    <= if_ack_d;
      d_ack     <= d_ack_d;
      err       <= err_d;
    end
  end

endmodule
